// File: rtl/aes_encrypt_iterative.sv
// Iterative AES encryption core: one round per clock with a valid/ready handshake on each side.
// The full key schedule is derived combinationally from the latched key register.
module aes_encrypt_iterative #(
  parameter int NK = 4  // 4, 6 or 8 (AES-128/192/256); other values unsupported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      plaintext,
  input  logic [0:32*NK-1]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      encrypted,
  output logic              busy
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t               fsm;
  logic [3:0]         rnd;
  logic [127:0]       state_reg;
  logic [32*NK-1:0]   key_reg;
  logic [32*NW-1:0]   w_all;
  logic [128*(NR+1)-1:0] rk_all;
  logic [127:0]       rk_cur;
  logic [127:0]       rk_last;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Byte n of the state lives at [127-8n -: 8]; n = 4*column + row.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Word i of the expanded key sits at w_all[32*i +: 32].
  always_comb begin
    logic [31:0] tmp;
    logic [7:0]  rc;
    w_all = '0;
    tmp   = '0;
    rc    = 8'h01;
    for (int i = 0; i < NK; i++)
      w_all[32*i +: 32] = key_reg[32*(NK-1-i) +: 32];
    for (int i = NK; i < NW; i++) begin
      tmp = w_all[32*(i-1) +: 32];
      if (i % NK == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        tmp = sub_word(tmp);
      end
      w_all[32*i +: 32] = w_all[32*(i-NK) +: 32] ^ tmp;
    end
  end

  always_comb begin
    rk_all = '0;
    for (int r = 0; r <= NR; r++)
      rk_all[128*r +: 128] = {w_all[32*(4*r) +: 32],     w_all[32*(4*r+1) +: 32],
                              w_all[32*(4*r+2) +: 32],   w_all[32*(4*r+3) +: 32]};
  end

  assign rk_cur  = rk_all[128*int'(rnd) +: 128];
  assign rk_last = rk_all[128*NR +: 128];

  // Datapath: rk[0] is the first four words of the key being latched, so it comes straight from the port.
  always_ff @(posedge clk) begin
    if (fsm == IDLE && in_valid) begin
      key_reg   <= key;
      state_reg <= plaintext ^ key[0:127];
    end else if (fsm == ROUND) begin
      state_reg <= mix_columns(sub_shift(state_reg)) ^ rk_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      encrypted <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            rnd      <= 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NR - 1)) fsm <= FINAL;
        end
        FINAL: begin
          encrypted <= sub_shift(state_reg) ^ rk_last;
          out_valid <= 1'b1;
          fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            rnd       <= '0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Directed bench for aes_encrypt_iterative: FIPS-197 vectors for all key sizes, latency,
// backpressure, input changes while busy and asynchronous reset mid-block.
module tb_aes_encrypt_iterative;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready, v6, v8;
  logic [0:127] plaintext, key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic         in_ready, out_valid, busy;
  logic [0:127] encrypted;
  logic         in_ready6, out_valid6, busy6, in_ready8, out_valid8, busy8;
  logic [0:127] enc6, enc8;
  int           total = 0;
  int           bad = 0;

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_encrypt_iterative #(.NK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key4), .out_valid(out_valid), .out_ready(out_ready),
    .encrypted(encrypted), .busy(busy));

  aes_encrypt_iterative #(.NK(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(in_ready6),
    .plaintext(plaintext), .key(key6), .out_valid(out_valid6), .out_ready(1'b1),
    .encrypted(enc6), .busy(busy6));

  aes_encrypt_iterative #(.NK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(in_ready8),
    .plaintext(plaintext), .key(key8), .out_valid(out_valid8), .out_ready(1'b1),
    .encrypted(enc8), .busy(busy8));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block; lat counts clock edges from the accepting edge until out_valid is seen.
  task automatic send(input logic [127:0] p, input logic [127:0] k, output int lat);
    @(negedge clk);
    plaintext = p;
    key4      = k;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic recv(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat, lat6, lat8;
    logic stable, stray;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; v6 = 1'b0; v8 = 1'b0;
    plaintext = '0; key4 = '0; key6 = '0; key8 = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_encrypted", encrypted, 0);
    chk("rst_ready6_busy6", {in_ready6, busy6}, 2'b10);
    chk("rst_ready8_busy8", {in_ready8, busy8}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: FIPS-197 appendix B vector with latency check
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send(PT1, KEY1, lat);
    chk("t1_latency", lat, 11);
    chk("t1_ct", encrypted, CT1);
    chk("t1_in_ready_done", in_ready, 0);
    recv("t1");

    // T2: appendix C vectors, AES-128/192/256
    send(PT2, 128'h000102030405060708090a0b0c0d0e0f, lat);
    chk("t2_128_ct", encrypted, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    recv("t2_128");
    @(negedge clk);
    plaintext = PT2;
    key6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    v6 = 1'b1; v8 = 1'b1;
    lat6 = 0; lat8 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      v6 = 1'b0; v8 = 1'b0;
      if (out_valid6 && lat6 == 0) lat6 = n;
      if (out_valid8 && lat8 == 0) lat8 = n;
    end
    chk("t2_192_latency", lat6, 13);
    chk("t2_256_latency", lat8, 15);
    chk("t2_192_ct", enc6, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("t2_256_ct", enc8, 128'h8ea2b7ca516745bfeafc49904b496089);

    // T3: backpressure for 20 cycles
    send(PT1, KEY1, lat);
    stable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || encrypted !== CT1) stable = 1'b0;
    end
    chk("t3_stable", stable, 1);
    chk("t3_ct", encrypted, CT1);
    recv("t3");
    chk("t3_ct_retained", encrypted, CT1);

    // T4: inputs scrambled and in_valid held high while the block is in flight
    send(PT2, 128'h000102030405060708090a0b0c0d0e0f, lat);
    recv("t4_pre");
    @(negedge clk);
    plaintext = PT1; key4 = KEY1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    lat = 1; stray = 1'b0;
    while (!out_valid && lat < 40) begin
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      key4      = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid  = 1'b1;
      if (in_ready || !busy) stray = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("t4_no_accept", stray, 0);
    chk("t4_latency", lat, 11);
    chk("t4_ct", encrypted, CT1);
    recv("t4");

    // T5: asynchronous reset during round 5, then a clean run
    @(negedge clk);
    plaintext = PT2; key4 = KEY1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_encrypted", encrypted, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(PT1, KEY1, lat);
    chk("t5_rerun_latency", lat, 11);
    chk("t5_rerun_ct", encrypted, CT1);
    recv("t5_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
